// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Optional sub-word access is enabled with the MEM_SUBWORD_EN macro.
package mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: write mask, replicated write
// word, and read data shifted down to bit 0 and zero-extended.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] rsh;
  assign rsh = rword >> {addr_lo, 3'b000};

  // Replicate store data across lanes so the mask alone selects the target.
  always_comb begin
    wmask = 4'hF;
    wword = wdata;
    rdata = rword;
    case (size)
      SZ_BYTE: begin
        wmask = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = {24'd0, rsh[7:0]};
      end
      SZ_HALF: begin
        wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {16'd0, rsh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Handshaked fixed-latency word RAM serving the core's memory port.
// Sub-word (byte/half) access is compiled in with MEM_SUBWORD_EN; otherwise
// every access is a full word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req_q, cur;
  logic [31:0]      ram [DEPTH];
  logic [AW-1:0]    idx;
  logic [1:0]       sz;
  logic             err, accept, enter_resp;
  logic [3:0]       wmask;
  logic [31:0]      wword, rword, rdata_al;

  // In IDLE the live inputs are the request (needed when LATENCY=1 goes
  // straight to RESP); afterwards only the latched copy is used.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.we    = req_we;
      cur.size  = req_size;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  assign idx   = cur.addr[AW+1:2];
  assign rword = ram[idx];

`ifdef MEM_SUBWORD_EN
  assign sz = (cur.size == 2'd3) ? SZ_WORD : cur.size;

  mem_lane_align u_align (
    .addr_lo (cur.addr[1:0]),
    .size    (sz),
    .wdata   (cur.wdata),
    .rword   (rword),
    .wmask   (wmask),
    .wword   (wword),
    .rdata   (rdata_al)
  );
`else
  logic unused_size;
  assign unused_size = ^cur.size;
  assign sz          = SZ_WORD;
  assign wmask       = 4'hF;
  assign wword       = cur.wdata;
  assign rdata_al    = rword;
`endif

  // Misalignment and out-of-range detection on the effective request.
  always_comb begin
    err = (cur.addr[31:2] >= 30'(DEPTH));
    case (sz)
      SZ_BYTE: ;
      SZ_HALF: err = err | cur.addr[0];
      default: err = err | (|cur.addr[1:0]);
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (accept && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt <= CNT_W'(1)));

  // Capture the request at accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) req_q <= cur;
  end

  // Request FSM and latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (LATENCY == 1) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (enter_resp) state <= RESP;
              else cnt <= cnt - 1'b1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response registers: loaded on entry to RESP, zero in every other cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp & err;
      rsp_rdata <= (enter_resp && !err && !cur.we) ? rdata_al : '0;
    end
  end

  // Store commit at the edge ending RESP; a reset on that edge abandons it.
  always_ff @(posedge clk) begin
    if (rst && (state == RESP) && req_q.we && !err) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ram[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

endmodule
